// File: rtl/prng_extend_byte_gen.sv
// 32-bit xorshift generator with a byte-wide port: the seed is loaded MSB byte first.
// Each request advances the generator and streams the new word out LSB byte first over 4 cycles.
module prng_extend_byte_gen #(
  parameter logic [31:0] DEFAULT_SEED = 32'h02468ACD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_seed,
  input  logic [7:0] data_in,
  input  logic       get_random,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {IDLE, LOAD, OUT} fsm_t;

  fsm_t        fsm, fsm_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] state, state_nxt;
  logic [31:0] seed, seed_nxt;
  logic [7:0]  dout_nxt;
  logic [31:0] seed_full;
  logic        ready;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] x1, x2;
    x1 = x ^ (x << 13);
    x2 = x1 ^ (x1 >> 17);
    return x2 ^ (x2 << 5);
  endfunction

  // The last OUT cycle (cnt wrapped to 0) accepts new commands like IDLE,
  // which allows one request every 4 cycles.
  assign ready     = (fsm == IDLE) || ((fsm == OUT) && (cnt == 2'd0));
  assign seed_full = {seed[23:0], data_in};

  always_comb begin
    fsm_nxt   = fsm;
    cnt_nxt   = cnt;
    state_nxt = state;
    seed_nxt  = seed;
    dout_nxt  = 8'h00;
    if (ready) begin
      cnt_nxt = 2'd0;
      if (load_seed) begin
        fsm_nxt = LOAD;
      end else if (get_random) begin
        state_nxt = xs_next(state);
        dout_nxt  = state_nxt[7:0];
        fsm_nxt   = OUT;
        cnt_nxt   = 2'd1;
      end else begin
        fsm_nxt = IDLE;
      end
    end else begin
      case (fsm)
        LOAD: begin
          seed_nxt = seed_full;
          cnt_nxt  = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = (seed_full == 32'h0) ? DEFAULT_SEED : seed_full;
            fsm_nxt   = IDLE;
          end
        end
        OUT: begin
          if (load_seed) begin
            fsm_nxt = LOAD;
            cnt_nxt = 2'd0;
          end else begin
            // state already holds the word being streamed
            case (cnt)
              2'd1:    dout_nxt = state[15:8];
              2'd2:    dout_nxt = state[23:16];
              default: dout_nxt = state[31:24];
            endcase
            cnt_nxt = cnt + 2'd1;
          end
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      fsm      <= IDLE;
      cnt      <= 2'd0;
      state    <= DEFAULT_SEED;
      seed     <= 32'h0;
      data_out <= 8'h00;
    end else begin
      fsm      <= fsm_nxt;
      cnt      <= cnt_nxt;
      state    <= state_nxt;
      seed     <= seed_nxt;
      data_out <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_prng_extend_byte_gen.sv
// Self-checking bench for prng_extend_byte_gen: constant vector table, corner sequences,
// and a long randomized run compared against an arithmetic xorshift model.
module tb_prng_extend_byte_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load_seed = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       get_random = 1'b0;
  logic [7:0] data_out;

  int n_chk = 0;
  int n_fail = 0;

  prng_extend_byte_gen dut (
    .clk(clk), .rstn(rstn), .load_seed(load_seed), .data_in(data_in),
    .get_random(get_random), .data_out(data_out)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DEF = 32'h02468ACD;

  function automatic logic [31:0] model_next(input logic [31:0] x);
    logic [31:0] a;
    a = x ^ (x * 32'd8192);
    a = a ^ (a / 32'd131072);
    return a ^ (a * 32'd32);
  endfunction

  typedef struct {
    logic        do_load;
    logic [31:0] seed;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1; load_seed = 1'b0; get_random = 1'b0; data_in = 8'h00;
    step(); step();
    rstn = 1'b0;
    step();
  endtask

  // Pulse load_seed, then feed 4 bytes MSB first; noise drives get_random throughout.
  task automatic load(input logic [31:0] s, input bit noise);
    load_seed = 1'b1;
    get_random = noise;
    step();
    load_seed = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      data_in = s[i*8 +: 8];
      get_random = noise;
      load_seed = noise;
      step();
    end
    load_seed = 1'b0;
    get_random = 1'b0;
    data_in = 8'h00;
  endtask

  // Request a word and reassemble it; noise toggles inputs during the stream cycles.
  task automatic get_word(output logic [31:0] w, input bit noise);
    get_random = 1'b1;
    step();
    w[7:0] = data_out;
    for (int i = 1; i < 4; i++) begin
      get_random = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      w[i*8 +: 8] = data_out;
    end
    get_random = 1'b0;
  endtask

  initial begin
    logic [31:0] w, exp, m;
    int gap;

    vecs[0] = '{1'b0, 32'h0,        32'hB0F72B02};
    vecs[1] = '{1'b1, 32'h00000001, 32'h00042021};
    vecs[2] = '{1'b1, 32'h00000000, 32'hB0F72B02};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h0003E01F};
    vecs[4] = '{1'b1, DEF,          32'hB0F72B02};

    do_reset();
    check("reset_dout", {24'h0, data_out}, 32'h0);

    // Table vectors, including byte order on the first word
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].do_load) load(vecs[v].seed, 1'b0);
      check("idle_dout", {24'h0, data_out}, 32'h0);
      get_random = 1'b1;
      step();
      get_random = 1'b0;
      check("lsb_first", {24'h0, data_out}, {24'h0, vecs[v].exp[7:0]});
      step(); step(); step();
      check("msb_last", {24'h0, data_out}, {24'h0, vecs[v].exp[31:24]});
      step();
      check("tail_zero", {24'h0, data_out}, 32'h0);
      do_reset();
      if (vecs[v].do_load) load(vecs[v].seed, 1'b0);
      get_word(w, 1'b0);
      check("vec_word", w, vecs[v].exp);
    end

    // Mid-stream reset clears output asynchronously and restarts from default seed
    do_reset();
    get_random = 1'b1; step(); get_random = 1'b0; step();
    rstn = 1'b1; #1;
    check("async_rst_dout", {24'h0, data_out}, 32'h0);
    step(); rstn = 1'b0; step();
    get_word(w, 1'b0);
    check("after_midrst", w, 32'hB0F72B02);

    // Back-to-back requests at k+4
    do_reset();
    get_word(w, 1'b0);
    check("b2b_first", w, 32'hB0F72B02);
    get_word(w, 1'b0);
    check("b2b_second", w, model_next(32'hB0F72B02));
    step();
    check("b2b_tail", {24'h0, data_out}, 32'h0);

    // get_random held during OUT and LOAD is ignored
    do_reset();
    get_random = 1'b1; step();
    step(); step(); step();
    get_random = 1'b0; step();
    load(32'h00000001, 1'b1);
    get_word(w, 1'b0);
    check("held_ignored", w, 32'h00042021);

    // load_seed during OUT aborts the stream
    do_reset();
    get_random = 1'b1; step(); get_random = 1'b0; step();
    load_seed = 1'b1; step(); load_seed = 1'b0;
    check("abort_dout", {24'h0, data_out}, 32'h0);
    for (int i = 3; i >= 0; i--) begin
      data_in = 8'(32'h00000001 >> (i*8));
      step();
    end
    get_word(w, 1'b0);
    check("abort_reload", w, 32'h00042021);

    // Long randomized run against the model
    do_reset();
    load(32'h830ADB1C, 1'b0);
    m = 32'h830ADB1C;
    for (int k = 0; k < 1000; k++) begin
      get_word(w, 1'b1);
      m = model_next(m);
      exp = m;
      check("rand_word", w, exp);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check("rand_idle", {24'h0, data_out}, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
